// File: rtl/ms_delay_arbiter.sv
// ms_delay_arbiter
//   Lets four requesters share one 1 ms tick generator. Round-robin grants
//   the timer to one requester, enables the tick source, counts ticks down
//   from the requested delay and then pulses that requester's done line.
//
// Ports
//   Clk        system clock (50 MHz)
//   Rst        asynchronous reset, active-high
//   req        per-requester request level, held until done (drop = abort)
//   req_dly    packed delays in ms, requester i at [i*DLY_W +: DLY_W],
//              sampled only when the grant is made
//   tick       1 ms pulse from the tick generator, one Clk wide
//   tick_en    enable to the tick generator (low restarts its count)
//   grant      one-hot owner of the timer, zero when idle
//   done       one-cycle completion pulse to the owner
//   busy       high whenever the arbiter is not idle
//   remaining  ms left for the current owner, zero when idle
module ms_delay_arbiter #(
  parameter int NREQ  = 4,
  parameter int DLY_W = 12
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DLY_W-1:0] req_dly,
  input  logic                  tick,
  output logic                  tick_en,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [DLY_W-1:0]      remaining
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     last_ptr_q, last_ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              tick_en_q, tick_en_d;
  logic              busy_q, busy_d;
  logic [DLY_W-1:0]  remaining_q, remaining_d;

  // Round-robin pick: first set req bit starting just after last_ptr.
  // The pointer wraps naturally because NREQ is a power of two.
  logic              pick_found;
  logic [PW-1:0]     pick_idx;
  logic [PW-1:0]     cand;
  logic [DLY_W-1:0]  pick_dly;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = last_ptr_q + PW'(k);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_dly = req_dly[pick_idx*DLY_W +: DLY_W];
  end

  always_comb begin
    state_d     = state_q;
    last_ptr_d  = last_ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    done_d      = '0;
    tick_en_d   = tick_en_q;
    remaining_d = remaining_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          last_ptr_d = pick_idx;
          owner_d    = pick_idx;
          if (pick_dly != '0) begin
            state_d     = COUNT;
            grant_d     = NREQ'(1) << pick_idx;
            remaining_d = pick_dly;
            tick_en_d   = 1'b1;
          end else begin
            // Zero delay completes without ever owning the timer.
            state_d = DONE;
            done_d  = NREQ'(1) << pick_idx;
          end
        end
      end

      COUNT: begin
        // Abort takes priority over a coincident tick.
        if (!req[owner_q]) begin
          state_d     = IDLE;
          grant_d     = '0;
          tick_en_d   = 1'b0;
          remaining_d = '0;
        end else if (tick) begin
          if (remaining_q == DLY_W'(1)) begin
            state_d     = DONE;
            done_d      = NREQ'(1) << owner_q;
            grant_d     = '0;
            tick_en_d   = 1'b0;
            remaining_d = '0;
          end else begin
            remaining_d = remaining_q - 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        grant_d     = '0;
        tick_en_d   = 1'b0;
        remaining_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      last_ptr_q  <= PW'(NREQ - 1);
      owner_q     <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      tick_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      last_ptr_q  <= last_ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      tick_en_q   <= tick_en_d;
      busy_q      <= busy_d;
      remaining_q <= remaining_d;
    end
  end

  assign tick_en   = tick_en_q;
  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign remaining = remaining_q;

endmodule
